// File: rtl/alu_pkg.sv
// Shared ALU control codes, R-type funct values and the mul/div sequencer state type.
package alu_pkg;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_XOR = 5'b01101;
    localparam logic [4:0] ALU_SLL = 5'b10000;
    localparam logic [4:0] ALU_SRL = 5'b11000;
    localparam logic [4:0] ALU_SRA = 5'b11001;
    localparam logic [4:0] ALU_MUL = 5'b11010;

    localparam logic [2:0] CLS_ADD   = 3'b000;
    localparam logic [2:0] CLS_SUB   = 3'b001;
    localparam logic [2:0] CLS_RTYPE = 3'b010;
    localparam logic [2:0] CLS_OR    = 3'b011;
    localparam logic [2:0] CLS_AND   = 3'b100;
    localparam logic [2:0] CLS_SLT   = 3'b101;
    localparam logic [2:0] CLS_MUL   = 3'b110;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/alu_mdu_ctrl_md_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract step per cycle.
// Divider path present only when ALU_MDU_DIV_EN is defined.
module md_iter
    import alu_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] ZERO_DIV_LO = '1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    step,
`ifdef ALU_MDU_DIV_EN
    input  logic                    is_div,
`endif
    input  logic                    is_signed,
    input  logic signed [WIDTH-1:0] opa,
    input  logic signed [WIDTH-1:0] opb,
    output logic                    last,
    output logic [WIDTH-1:0]        hi_res,
    output logic [WIDTH-1:0]        lo_res
);

    localparam int CW = $clog2(WIDTH) + 1;

    function automatic logic [WIDTH-1:0] cneg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg2(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [CW-1:0]      cnt;
    logic               neg_res;

`ifdef ALU_MDU_DIV_EN
    logic               div_op;
    logic               div_zero;
    logic               neg_rem;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
`else
    logic               unused_cfg;
    assign unused_cfg = ^ZERO_DIV_LO;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc     <= {{WIDTH{1'b0}}, cneg(is_signed & opa[WIDTH-1], opa)};
            mag_b   <= cneg(is_signed & opb[WIDTH-1], opb);
            neg_res <= is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
`ifdef ALU_MDU_DIV_EN
            neg_rem  <= is_signed & opa[WIDTH-1];
            div_op   <= is_div;
            div_zero <= (opb == '0);
`endif
        end else if (step) begin
            acc <= acc_nxt;
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        acc_nxt = {mul_sum, acc[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_sh - {1'b0, mag_b};
        // a set top bit means the shifted remainder already exceeds any WIDTH-bit divisor
        div_fits = div_sh[WIDTH] | ~div_diff[WIDTH];
        if (div_op) begin
            if (div_zero) begin
                acc_nxt = acc;
            end else if (div_fits) begin
                acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        prod   = cneg2(neg_res, acc);
        hi_res = prod[2*WIDTH-1:WIDTH];
        lo_res = prod[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
        if (div_op) begin
            if (div_zero) begin
                // dividend was held untouched in the low half; restore its sign for HI
                hi_res = cneg(neg_rem, acc[WIDTH-1:0]);
                lo_res = ZERO_DIV_LO;
            end else begin
                hi_res = cneg(neg_rem, acc[2*WIDTH-1:WIDTH]);
                lo_res = cneg(neg_res, acc[WIDTH-1:0]);
            end
        end
`endif
    end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU control decode plus HI/LO mul/div sequencer with pipeline stall.
// Define ALU_MDU_DIV_EN to enable DIV/DIVU; otherwise they decode as no-ops.
module alu_mdu_ctrl
    import alu_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] ZERO_DIV_LO = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic             InValid,
    input  logic             Flush,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic [4:0]       ALUCtl,
    output logic             Sign,
    output logic             Stall,
    output logic [WIDTH-1:0] HiLoData,
    output logic             Busy
);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic             rtype;
    logic             md_start;
    logic             md_load;
    logic             md_step;
    logic             md_last;
    logic             hilo_we;
    logic             mthi_we;
    logic             mtlo_we;
    logic             stall_c;

    assign rtype = (ALUOp[2:0] == CLS_RTYPE);

`ifdef ALU_MDU_DIV_EN
    assign md_start = rtype & ((Funct == F_MULT) | (Funct == F_MULTU) |
                               (Funct == F_DIV)  | (Funct == F_DIVU));
`else
    assign md_start = rtype & ((Funct == F_MULT) | (Funct == F_MULTU));
`endif

    always_comb begin
        ALUCtl = ALU_ADD;
        case (ALUOp[2:0])
            CLS_ADD:   ALUCtl = ALU_ADD;
            CLS_SUB:   ALUCtl = ALU_SUB;
            CLS_OR:    ALUCtl = ALU_OR;
            CLS_AND:   ALUCtl = ALU_AND;
            CLS_SLT:   ALUCtl = ALU_SLT;
            CLS_MUL:   ALUCtl = ALU_MUL;
            CLS_RTYPE: begin
                casez (Funct)
                    6'b000000: ALUCtl = ALU_SLL;
                    6'b000010: ALUCtl = ALU_SRL;
                    6'b000011: ALUCtl = ALU_SRA;
                    6'b10000?: ALUCtl = ALU_ADD;
                    6'b10001?: ALUCtl = ALU_SUB;
                    6'b100100: ALUCtl = ALU_AND;
                    6'b100101: ALUCtl = ALU_OR;
                    6'b100110: ALUCtl = ALU_XOR;
                    6'b100111: ALUCtl = ALU_NOR;
                    6'b10101?: ALUCtl = ALU_SLT;
                    default:   ALUCtl = ALU_ADD;
                endcase
            end
            default:   ALUCtl = ALU_ADD;
        endcase
        Sign = rtype ? ~Funct[0] : ~ALUOp[3];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        md_load   = 1'b0;
        md_step   = 1'b0;
        hilo_we   = 1'b0;
        mthi_we   = 1'b0;
        mtlo_we   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (InValid & ~Flush) begin
                    if (md_start) begin
                        stall_c   = 1'b1;
                        md_load   = 1'b1;
                        state_nxt = ST_RUN;
                    end
                    mthi_we = rtype & (Funct == F_MTHI);
                    mtlo_we = rtype & (Funct == F_MTLO);
                end
            end
            ST_RUN: begin
                if (Flush) begin
                    state_nxt = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                    md_step = 1'b1;
                    if (md_last) begin
                        state_nxt = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (Flush) begin
                    state_nxt = ST_IDLE;
                end else begin
                    stall_c   = 1'b1;
                    hilo_we   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            // held instruction is released here; it must not restart the unit
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hilo_we) begin
                hi <= md_hi;
                lo <= md_lo;
            end
            if (mthi_we) begin
                hi <= OpA;
            end
            if (mtlo_we) begin
                lo <= OpA;
            end
        end
    end

    assign Stall    = stall_c & ~reset;
    assign Busy     = (state != ST_IDLE);
    assign HiLoData = (Funct == F_MFHI) ? hi : lo;

    md_iter #(
        .WIDTH       (WIDTH),
        .ZERO_DIV_LO (ZERO_DIV_LO)
    ) u_md_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (md_load),
        .step      (md_step),
`ifdef ALU_MDU_DIV_EN
        .is_div    (Funct[1]),
`endif
        .is_signed (~Funct[0]),
        .opa       (OpA),
        .opb       (OpB),
        .last      (md_last),
        .hi_res    (md_hi),
        .lo_res    (md_lo)
    );

endmodule

// File: doc/alu_mdu_ctrl.md
ALU_MDU_CTRL -- requirements
Module: alu_mdu_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, datapath width (even, >=8).
REQ-002 Parameter ZERO_DIV_LO, default all-ones, LO value on divide-by-zero.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ALUOp  input  4  main-decoder ALU op; [3]=unsigned flag, [2:0]=op class.
REQ-006 Funct  input  6  R-type funct field.
REQ-007 InValid  input  1  EX-stage instruction valid.
REQ-008 Flush  input  1  kill EX instruction and any running mul/div.
REQ-009 OpA, OpB  input  WIDTH each  rs/rt operand values.
REQ-010 ALUCtl  output  5  ALU function code.
REQ-011 Sign  output  1  ALU signed-compare/overflow mode.
REQ-012 Stall  output  1  hold IF/ID/EX while high.
REQ-013 HiLoData  output  WIDTH  HI or LO value for MFHI/MFLO.
REQ-014 Busy  output  1  state != IDLE.

Function
REQ-015 ALUCtl combinational: class 000 ADD, 001 SUB, 011 OR, 100 AND, 101 SLT, 110 MUL, 010 per Funct, other ADD.
REQ-016 Class 010 Funct map: 000000 SLL, 000010 SRL, 000011 SRA, 10000x ADD, 10001x SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 10101x SLT, other ADD.
REQ-017 Sign = ~Funct[0] when class 010, else ~ALUOp[3].
REQ-018 MD ops (class 010): MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
REQ-019 FSM states IDLE, RUN, FIX, DONE; reset and Flush force IDLE.
REQ-020 IDLE: InValid & MD-start & ~Flush -> capture |OpA|, |OpB|, result sign, counter=0, go RUN; Stall=1 that cycle.
REQ-021 RUN: one shift-add (mul) or restoring subtract (div) step per cycle; exactly WIDTH cycles; then FIX.
REQ-022 FIX: apply two's-complement sign correction, write HI/LO at end of cycle; go DONE.
REQ-023 DONE: Stall=0, start suppressed, go IDLE next cycle; total stall WIDTH+2 cycles.
REQ-024 Stall = (state==IDLE & InValid & MD-start & ~Flush) | state in {RUN, FIX}.
REQ-025 MULT/MULTU: {HI,LO} = 2*WIDTH-bit product; signed for MULT.
REQ-026 DIV/DIVU: LO=quotient, HI=remainder; remainder takes dividend sign (truncating).
REQ-027 Divisor zero: HI=OpA, LO=ZERO_DIV_LO, same latency.
REQ-028 Signed MIN / -1: LO=MIN, HI=0.
REQ-029 MTHI/MTLO in IDLE with InValid: write HI/LO from OpA at clock edge, no stall.
REQ-030 HiLoData = HI when Funct==010000 else LO, combinational from registers.
REQ-031 Flush during RUN/FIX: abort, HI/LO unchanged, IDLE next cycle, Stall low in the Flush cycle.
REQ-032 Operand inputs ignored after start cycle.

Reset
REQ-033 Synchronous: state IDLE, HI=0, LO=0, counter=0, Stall=0, Busy=0.
REQ-034 Reset mid-operation overrides Flush and completion; no HI/LO write that cycle.
REQ-035 ALUCtl/Sign combinational, not affected by reset.

Configuration
REQ-036 Macro ALU_MDU_DIV_EN: defined -> divider path per REQ-021/026-028.
REQ-037 Undefined: DIV/DIVU decoded as no-op, no stall, HI/LO unchanged; divider logic absent.

Structure
REQ-038 Package alu_pkg: ALUCtl codes (AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, NOR 01100, XOR 01101, SLL 10000, SRL 11000, SRA 11001, MUL 11010), funct constants, FSM state enum.
REQ-039 One sub-module md_iter: iterative mul/div datapath (accumulator, counter, step logic); FSM and decode remain in alu_mdu_ctrl.

Verification
REQ-040 ALUOp=0010, Funct=100011 -> ALUCtl=00110, Sign=0; ALUOp=0101 -> ALUCtl=00111, Sign=1.
REQ-041 MULT OpA=-3, OpB=7, WIDTH=32 -> Stall high 34 cycles, then HI=FFFFFFFF, LO=FFFFFFEB.
REQ-042 DIV OpA=-7, OpB=2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 7/0 -> HI=7, LO=FFFFFFFF.
REQ-043 MULTU started, Flush at RUN cycle 10 -> IDLE next cycle, HI/LO retain prior values, Stall low.
REQ-044 MTLO 0x1234 then MFLO next cycle -> HiLoData=0x1234, no stall; reset mid-DIV -> HI=LO=0, Busy=0.
REQ-045 Build without ALU_MDU_DIV_EN, DIV issued -> Stall never high, HI/LO unchanged.
